// File: rtl/line_ack_decoder_if.sv
// Acknowledge handshake bundle: serviced line index with valid/ready.
interface line_ack_decoder_if #(
  parameter int unsigned IN_WIDTH = 1
) ();

  logic [IN_WIDTH-1:0] ack_index;
  logic                ack_valid;
  logic                ack_ready;

  modport master (
    output ack_index,
    output ack_valid,
    input  ack_ready
  );

  modport slave (
    input  ack_index,
    input  ack_valid,
    output ack_ready
  );

endinterface

// File: rtl/line_ack_decoder.sv
// line_ack_decoder: holds pending request lines, accepts the serviced index over a
// valid/ready handshake, clears that pending bit and pulses a one-hot acknowledge.
// Optional feature macro: LINE_ACK_SPURIOUS_EN (acks to non-pending lines are counted
// as spurious and suppressed instead of pulsed).
module line_ack_decoder #(
  parameter int unsigned IN_WIDTH = 1,
  parameter int unsigned LINES    = 1 << IN_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LINES-1:0]    set_lines,
  output logic [LINES-1:0]    pending,
  line_ack_decoder_if.slave   ack,
  output logic [LINES-1:0]    ack_lines,
  output logic                ack_done,
  output logic                ack_error,
  output logic [7:0]          spurious_count
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] idx;
  logic                accept;
  logic                in_range;
  logic [LINES-1:0]    dec;
  logic                take;
  logic                spurious;
  logic [LINES-1:0]    clear_mask;

  assign idx = ack.ack_index;

  // Ready only in IDLE and never while reset is held.
  assign ack.ack_ready = (state == IDLE) & ~reset;

  // Decode the offered index and classify the accept (valid target, out of range, spurious).
  always_comb begin
    accept   = ack.ack_valid & ack.ack_ready;
    dec      = LINES'(1) << idx;
    in_range = 32'(idx) < LINES;
`ifdef LINE_ACK_SPURIOUS_EN
    take     = accept & in_range & (|(pending & dec));
    spurious = accept & in_range & ~(|(pending & dec));
`else
    take     = accept & in_range;
    spurious = 1'b0;
`endif
    clear_mask = take ? dec : '0;
  end

  // FSM plus registered pending mask, ack pulses and spurious counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pending        <= '0;
      ack_lines      <= '0;
      ack_done       <= 1'b0;
      ack_error      <= 1'b0;
      spurious_count <= 8'd0;
    end else begin
      // Set is applied after clear so a same-cycle request on the acked line survives.
      pending   <= (pending & ~clear_mask) | set_lines;
      ack_lines <= clear_mask;
      ack_done  <= take;
      ack_error <= accept & ~in_range;
      if (spurious && (spurious_count != 8'hFF)) begin
        spurious_count <= spurious_count + 8'd1;
      end
      case (state)
        IDLE:    if (accept) state <= ACK;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_ack_decoder.sv
// Bench for line_ack_decoder (IN_WIDTH=3, LINES=6): directed table, hand sequences,
// randomized traffic against a cycle-counting reference model.
module tb_line_ack_decoder;

  localparam int unsigned IN_WIDTH = 3;
  localparam int unsigned LINES    = 6;
`ifdef LINE_ACK_SPURIOUS_EN
  localparam bit SPUR = 1'b1;
`else
  localparam bit SPUR = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [LINES-1:0] set_lines;
  logic [LINES-1:0] pending;
  logic [LINES-1:0] ack_lines;
  logic             ack_done;
  logic             ack_error;
  logic [7:0]       spurious_count;

  line_ack_decoder_if #(.IN_WIDTH(IN_WIDTH)) ackif ();

  line_ack_decoder #(.IN_WIDTH(IN_WIDTH), .LINES(LINES)) dut (
    .clk            (clk),
    .reset          (reset),
    .set_lines      (set_lines),
    .pending        (pending),
    .ack            (ackif),
    .ack_lines      (ack_lines),
    .ack_done       (ack_done),
    .ack_error      (ack_error),
    .spurious_count (spurious_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending mask as plain bits, readiness from the edge of the last accept.
  logic [LINES-1:0] m_pending;
  logic [LINES-1:0] m_lines;
  bit               m_done;
  bit               m_err;
  int               m_count;
  int               m_cyc;
  int               m_last;
  bit               pre_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_cyc);
    end
  endtask

  // One clock: drive at negedge, check ready, advance model at posedge, check outputs.
  task automatic step(input logic [LINES-1:0] s, input bit v, input logic [IN_WIDTH-1:0] i,
                      input bit r);
    bit               exp_rdy;
    bit               acc;
    logic [LINES-1:0] clr;
    @(negedge clk);
    set_lines       = s;
    ackif.ack_valid = v;
    ackif.ack_index = i;
    reset           = r;
    #1;
    exp_rdy   = !r && ((m_cyc - m_last) >= 2);
    pre_ready = ackif.ack_ready;
    chk("ack_ready", 32'(ackif.ack_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_pending = '0; m_lines = '0; m_done = 0; m_err = 0; m_count = 0; m_last = -10;
    end else begin
      acc = v && exp_rdy;
      m_lines = '0; m_done = 0; m_err = 0; clr = '0;
      if (acc) begin
        m_last = m_cyc;
        if (int'(i) >= int'(LINES)) m_err = 1;
        else if (!SPUR || m_pending[i]) begin
          clr = LINES'(1) << i; m_lines = clr; m_done = 1;
        end else if (m_count < 255) m_count++;
      end
      m_pending = (m_pending & ~clr) | s;
    end
    m_cyc++;
    #1;
    chk("pending",        32'(pending),        32'(m_pending));
    chk("ack_lines",      32'(ack_lines),      32'(m_lines));
    chk("ack_done",       32'(ack_done),       32'(m_done));
    chk("ack_error",      32'(ack_error),      32'(m_err));
    chk("spurious_count", 32'(spurious_count), 32'(m_count));
  endtask

  typedef struct {
    logic [LINES-1:0]    set;
    bit                  v;
    logic [IN_WIDTH-1:0] idx;
    bit                  rdy;
    logic [LINES-1:0]    pend;
    logic [LINES-1:0]    lines;
    bit                  done;
    bit                  err;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int done_cnt;
    int lines_cnt;
    int first_done;
    int second_done;
    logic [LINES-1:0] first_lines;
    logic [LINES-1:0] second_lines;

    // {set, valid, index, ready before edge, pending, ack_lines, ack_done, ack_error} after edge
    tbl[0]  = '{6'h24, 1'b0, 3'd0, 1'b1, 6'h24, 6'h00, 1'b0, 1'b0};
    tbl[1]  = '{6'h00, 1'b1, 3'd5, 1'b1, 6'h04, 6'h20, 1'b1, 1'b0};
    tbl[2]  = '{6'h00, 1'b0, 3'd0, 1'b0, 6'h04, 6'h00, 1'b0, 1'b0};
    tbl[3]  = '{6'h00, 1'b0, 3'd0, 1'b1, 6'h04, 6'h00, 1'b0, 1'b0};
    tbl[4]  = '{6'h00, 1'b1, 3'd7, 1'b1, 6'h04, 6'h00, 1'b0, 1'b1};
    tbl[5]  = '{6'h00, 1'b0, 3'd0, 1'b0, 6'h04, 6'h00, 1'b0, 1'b0};
    tbl[6]  = '{6'h00, 1'b1, 3'd6, 1'b1, 6'h04, 6'h00, 1'b0, 1'b1};
    tbl[7]  = '{6'h00, 1'b0, 3'd0, 1'b0, 6'h04, 6'h00, 1'b0, 1'b0};
    tbl[8]  = '{6'h01, 1'b0, 3'd0, 1'b1, 6'h05, 6'h00, 1'b0, 1'b0};
    tbl[9]  = '{6'h01, 1'b1, 3'd0, 1'b1, 6'h05, 6'h01, 1'b1, 1'b0};
    tbl[10] = '{6'h00, 1'b0, 3'd0, 1'b0, 6'h05, 6'h00, 1'b0, 1'b0};
    tbl[11] = '{6'h00, 1'b1, 3'd2, 1'b1, 6'h01, 6'h04, 1'b1, 1'b0};
    tbl[12] = '{6'h00, 1'b1, 3'd0, 1'b0, 6'h01, 6'h00, 1'b0, 1'b0};
    tbl[13] = '{6'h00, 1'b1, 3'd0, 1'b1, 6'h00, 6'h01, 1'b1, 1'b0};
    tbl[14] = '{6'h00, 1'b0, 3'd0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0};

    m_pending = '0; m_lines = '0; m_done = 0; m_err = 0;
    m_count = 0; m_cyc = 0; m_last = -10;
    reset = 1'b1; set_lines = '0; ackif.ack_valid = 1'b0; ackif.ack_index = '0;

    // Reset, then 10 idle cycles.
    step('0, 1'b0, '0, 1'b1);
    step('0, 1'b1, 3'd1, 1'b1);
    for (int k = 0; k < 10; k++) step('0, 1'b0, '0, 1'b0);

    // Directed table.
    for (int k = 0; k < 15; k++) begin
      step(tbl[k].set, tbl[k].v, tbl[k].idx, 1'b0);
      chk($sformatf("tbl%0d.ready", k), 32'(pre_ready), 32'(tbl[k].rdy));
      chk($sformatf("tbl%0d.pending", k), 32'(pending), 32'(tbl[k].pend));
      chk($sformatf("tbl%0d.lines", k), 32'(ack_lines), 32'(tbl[k].lines));
      chk($sformatf("tbl%0d.done", k), 32'(ack_done), 32'(tbl[k].done));
      chk($sformatf("tbl%0d.error", k), 32'(ack_error), 32'(tbl[k].err));
    end

    // ack_valid held high, index 2 then 3: accepts land two cycles apart.
    step(6'h0C, 1'b0, '0, 1'b0);
    first_done = -1; second_done = -1; first_lines = '0; second_lines = '0;
    for (int k = 0; k < 4; k++) begin
      step('0, 1'b1, (k == 0) ? 3'd2 : 3'd3, 1'b0);
      if (ack_done && first_done < 0) begin first_done = k; first_lines = ack_lines; end
      else if (ack_done && second_done < 0) begin second_done = k; second_lines = ack_lines; end
    end
    chk("held.spacing", 32'(second_done - first_done), 32'd2);
    chk("held.first_lines", 32'(first_lines), 32'h04);
    chk("held.second_lines", 32'(second_lines), 32'h08);
    step('0, 1'b0, '0, 1'b0);

    // Reset asserted in the ACK cycle: no pulse escapes.
    step(6'h02, 1'b0, '0, 1'b0);
    step('0, 1'b1, 3'd1, 1'b0);
    step('0, 1'b0, '0, 1'b1);
    chk("rst_mid.lines", 32'(ack_lines), 32'h0);
    chk("rst_mid.done", 32'(ack_done), 32'h0);
    step('0, 1'b0, '0, 1'b0);
    chk("rst_mid.lines2", 32'(ack_lines), 32'h0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step(LINES'($urandom & $urandom & $urandom), 1'($urandom_range(1)),
           IN_WIDTH'($urandom_range(7)), ($urandom_range(63) == 0));
    end

    // 300 accepts of index 1 with nothing pending.
    step('0, 1'b0, '0, 1'b1);
    done_cnt = 0; lines_cnt = 0;
    for (int k = 0; k < 600; k++) begin
      step('0, 1'b1, 3'd1, 1'b0);
      if (ack_done) done_cnt++;
      if (ack_lines != '0) lines_cnt++;
    end
    step('0, 1'b0, '0, 1'b0);
    chk("burst.done_pulses", 32'(done_cnt), SPUR ? 32'd0 : 32'd300);
    chk("burst.line_pulses", 32'(lines_cnt), SPUR ? 32'd0 : 32'd300);
    chk("burst.spurious_count", 32'(spurious_count), SPUR ? 32'd255 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
